// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store stage in front of shared-RAM port 2. It checks requests,
//            sequences the port and returns sign-extended, tagged responses.
//            Width encoding on req_mode/memMode: 0=word, 1=half, 2=byte
//            (3 is treated as byte).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 131072,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [4:0]  req_rd,
    output logic        port2en,
    output logic        port2WEn,
    output logic [31:0] port2adr,
    output logic [31:0] port2i,
    output logic [1:0]  memMode,
    input  logic [31:0] port2o,
    input  logic        port2avail,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [1:0]  rsp_fault
);

    localparam logic [1:0] c_mode_word    = 2'd0;
    localparam logic [1:0] c_mode_half    = 2'd1;
    localparam logic [1:0] c_fault_ok     = 2'd0;
    localparam logic [1:0] c_fault_align  = 2'd1;
    localparam logic [1:0] c_fault_range  = 2'd2;
    localparam logic [1:0] c_fault_tmo    = 2'd3;
    localparam int         c_cnt_w        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_LD  = 3'd2,
        S_WAIT_WR1 = 3'd3,
        S_WAIT_WR2 = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t               state_q,     state_d;
    logic [31:0]          addr_q,      addr_d;
    logic [31:0]          wdata_q,     wdata_d;
    logic [1:0]           mode_q,      mode_d;
    logic                 signed_q,    signed_d;
    logic                 we_q,        we_d;
    logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 port2en_q,   port2en_d;
    logic                 port2wen_q,  port2wen_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q,  rsp_data_d;
    logic [4:0]           rsp_rd_q,    rsp_rd_d;
    logic [1:0]           rsp_fault_q, rsp_fault_d;

    logic [32:0]          w_size;
    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic [31:0]          w_load_data;

    // Checks run on the incoming request so the verdict is known at accept.
    always_comb begin
        case (req_mode)
            c_mode_word: w_size = 33'd4;
            c_mode_half: w_size = 33'd2;
            default:     w_size = 33'd1;
        endcase
    end

    assign w_misaligned   = ((req_mode == c_mode_word) && (req_addr[1:0] != 2'b00))
                         || ((req_mode == c_mode_half) && req_addr[0]);
    assign w_out_of_range = {1'b0, req_addr} > (33'(MEM_BYTES) - w_size);

    // RAM data arrives right-aligned and zero-extended; only sign fill is added.
    always_comb begin
        case (mode_q)
            c_mode_word: w_load_data = port2o;
            c_mode_half: w_load_data = {{16{signed_q & port2o[15]}}, port2o[15:0]};
            default:     w_load_data = {{24{signed_q & port2o[7]}}, port2o[7:0]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mode_d      = mode_q;
        signed_d    = signed_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        port2en_d   = 1'b0;
        port2wen_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_fault_d = rsp_fault_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    mode_d      = req_mode;
                    signed_d    = req_signed;
                    we_d        = req_we;
                    rsp_rd_d    = req_rd;
                    rsp_data_d  = 32'd0;
                    req_ready_d = 1'b0;
                    if (w_misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = c_fault_align;
                    end else if (w_out_of_range) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = c_fault_range;
                    end else begin
                        state_d     = S_ISSUE;
                        port2en_d   = 1'b1;
                        port2wen_d  = req_we;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? S_WAIT_WR1 : S_WAIT_LD;
            end
            S_WAIT_LD: begin
                if (port2avail) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = w_load_data;
                    rsp_fault_d = c_fault_ok;
                end else if (cnt_q == c_cnt_last) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'd0;
                    rsp_fault_d = c_fault_tmo;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_WR1: begin
                state_d = S_WAIT_WR2;
            end
            S_WAIT_WR2: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 32'd0;
                rsp_fault_d = c_fault_ok;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 32'd0;
                    rsp_rd_d    = 5'd0;
                    rsp_fault_d = c_fault_ok;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mode_q      <= 2'd0;
            signed_q    <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            port2en_q   <= 1'b0;
            port2wen_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_rd_q    <= 5'd0;
            rsp_fault_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mode_q      <= mode_d;
            signed_q    <= signed_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            port2en_q   <= port2en_d;
            port2wen_q  <= port2wen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign port2en   = port2en_q;
    assign port2WEn  = port2wen_q;
    assign port2adr  = addr_q;
    assign port2i    = wdata_q;
    assign memMode   = mode_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_fault = rsp_fault_q;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly upstream of the shared-RAM second port. It takes one memory request from execute over a valid/ready handshake and performs alignment and range checks.
- It sequences port2en/port2WEn with the RAM's fixed timing: a load result is available 1 cycle after issue, and a read-modify-write completes 3 cycles after issue.
- It sign-extends sub-word loads and returns a tagged response to writeback over a valid/ready handshake. Only one request is in flight at a time.

Parameters:
- MEM_BYTES, 131072, addressable bytes; an address >= MEM_BYTES faults.
- TIMEOUT, 8, cycles to wait for port2avail after a load issue before a fault is raised.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address (cpu_word)
- req_wdata  in  32  store data, right-aligned
- req_mode  in  mem_mode  access width: base::mem_mode word/half/byte values
- req_signed  in  1  sign-extend sub-word load
- req_rd  in  5  destination tag, echoed in the response
- port2en  out  1  RAM port-2 request strobe
- port2WEn  out  1  RAM port-2 write enable
- port2adr  out  32  RAM port-2 address
- port2i  out  32  RAM port-2 write data
- memMode  out  mem_mode  RAM port-2 access width
- port2o  in  32  RAM load data, right-aligned and zero-extended
- port2avail  in  1  port2o valid this cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  load result; 0 for stores and faults
- rsp_rd  out  5  echoed tag
- rsp_fault  out  2  0=ok, 1=misaligned, 2=out of range, 3=timeout

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - All outputs go to 0 except req_ready=1.
  - Latched request registers are cleared.
  - An in-flight operation is abandoned with no response.
- States: IDLE, ISSUE, WAIT_LD, WAIT_WR1, WAIT_WR2, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/mode/signed/we/rd, then run the checks:
  - misaligned: word with addr[1:0]!=0, or half with addr[0]!=0; reported as fault 1.
  - out of range: addr > MEM_BYTES - size; reported as fault 2.
  - Misaligned takes priority over out of range.
  - Any fault goes to RESP with rsp_data=0. No port2 activity occurs.
  - Otherwise go to ISSUE.
- port2adr/port2i/memMode are always driven from the latched registers and stay stable from ISSUE through completion.
- ISSUE: port2en=1 and port2WEn=latched we, for exactly one cycle. Next state is WAIT_LD for a load, WAIT_WR1 for a store.
- WAIT_LD:
  - If port2avail=1, capture port2o and go to RESP.
  - Sign extension when req_signed=1: half from bit 15, byte from bit 7.
  - Sign extension is ignored for word loads and for unsigned loads (zero-extended).
  - A counter increments every cycle in WAIT_LD. When it reaches TIMEOUT without port2avail, go to RESP with fault 3.
- WAIT_WR1 then WAIT_WR2: fixed two cycles covering the RAM read and rewrite. Then go to RESP, fault 0, rsp_data=0.
- RESP:
  - rsp_valid=1. rsp_data/rsp_rd/rsp_fault are held stable while rsp_ready=0.
  - On rsp_ready=1, return to IDLE.
  - req_ready=0 while in RESP; there is no same-cycle bypass.
- port2en is never asserted outside ISSUE. Any port2avail outside WAIT_LD is ignored.
- Latency from request accept to rsp_valid, with no backpressure:
  - load: 3 cycles
  - store: 4 cycles
  - fault: 1 cycle
- Throughput: one request per latency+1 cycles.

Test Plan:
- Word load, addr 0x100, RAM word 0xDEADBEEF, port2avail 1 cycle after port2en -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEF, rsp_fault=0, port2en high exactly 1 cycle.
- Signed byte load, addr 0x101, port2o=0x000000BE -> rsp_data=0xFFFFFFBE; the same access unsigned -> 0x000000BE.
- Half store, addr 0x202, wdata 0x1234 -> port2en=1 and port2WEn=1 for 1 cycle, port2adr=0x202, rsp_valid 4 cycles after accept, rsp_data=0; a subsequent half load of 0x202 returns 0x1234.
- Word load at 0x103 -> rsp_fault=1 next cycle, no port2en. Word load at 0x20000 -> rsp_fault=2.
- port2avail held 0 -> rsp_fault=3 after TIMEOUT=8 cycles in WAIT_LD. rsp_ready held 0 for 5 cycles -> response stable and req_ready=0 throughout.
- reset=0 asserted during WAIT_WR1 -> next cycle rsp_valid=0 and req_ready=1; no response is ever emitted for the aborted store.
